// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its prescaler.
package stopwatch_pkg;

    // Controller states; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } sw_state_t;

    // Clocks per count-enable tick unless the instantiating block overrides it.
    localparam int TICK_DIV_DEFAULT = 4;

    // True in the states where time is advancing.
    function automatic logic is_running(input sw_state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler that divides clk down to one-cycle count-enable ticks.
// It counts only while run is high, holds its value otherwise, and is
// cleared by zero (which wins over run).
module tick_gen
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic zero,
    output logic tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;

    // Advance the prescaler and emit a registered tick on each wrap.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            tick  <= 1'b0;
        end else if (zero) begin
            pre_q <= '0;
            tick  <= 1'b0;
        end else if (run) begin
            if (pre_q == LAST) begin
                pre_q <= '0;
                tick  <= 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
                tick  <= 1'b0;
            end
        end else begin
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/stop/lap/clear FSM driving an external digit
// chain through cnt_en/cnt_clr, with a lap-freezable display register.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int DW       = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_start,
    input  logic          btn_lap,
    input  logic [DW-1:0] cnt_in,
    output logic          cnt_en,
    output logic          cnt_clr,
    output logic [DW-1:0] disp_out,
    output logic          running,
    output logic          lap_active,
    output logic [1:0]    state
);

    sw_state_t state_q;
    sw_state_t state_d;
    logic      clr_d;
    logic      hold_disp;
    logic      run_next;
    logic      zero_next;

    // Next-state and clear-request decode; btn_start outranks btn_lap.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_start) begin
                    state_d = RUN;
                end else if (btn_lap) begin
                    clr_d = 1'b1;
                end
            end
            RUN: begin
                if (btn_start) begin
                    state_d = STOP;
                end else if (btn_lap) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (btn_start) begin
                    state_d = STOP;
                end else if (btn_lap) begin
                    state_d = RUN;
                end
            end
            STOP: begin
                if (btn_start) begin
                    state_d = RUN;
                end else if (btn_lap) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The prescaler follows the state being entered, so the edge leaving
    // RUN/LAP never produces a tick that would land in STOP or IDLE.
    assign run_next  = is_running(state_d);
    assign zero_next = (state_d == IDLE);

    // Display freezes only while staying in LAP; the edge into LAP captures
    // cnt_in and the edge out of LAP resumes live tracking.
    assign hold_disp = (state_q == LAP) && (state_d == LAP);

    // State register and one-cycle clear pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_clr <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_clr <= clr_d;
        end
    end

    // Display register: live copy of cnt_in, or the frozen lap value.
    // NOTE: the display register is reset along with the control state so a
    // frozen lap value cannot survive a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_out <= '0;
        end else if (!hold_disp) begin
            disp_out <= cnt_in;
        end
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run_next),
        .zero  (zero_next),
        .tick  (cnt_en)
    );

    assign running    = is_running(state_q);
    assign lap_active = (state_q == LAP);
    assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with TICK_DIV=4, DW=12.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_stopwatch_ctrl;

    logic        clk;
    logic        reset;
    logic        btn_start;
    logic        btn_lap;
    logic [11:0] cnt_in;
    logic        cnt_en;
    logic        cnt_clr;
    logic [11:0] disp_out;
    logic        running;
    logic        lap_active;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_ctrl #(
        .TICK_DIV (4),
        .DW       (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_start  (btn_start),
        .btn_lap    (btn_lap),
        .cnt_in     (cnt_in),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .disp_out   (disp_out),
        .running    (running),
        .lap_active (lap_active),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
    endtask

    task automatic press_lap();
        btn_lap = 1'b1;
        @(negedge clk);
        btn_lap = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        btn_start = 1'b1;
        cnt_in    = 12'h123;
        repeat (3) @(negedge clk);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if (disp_out !== 12'h000) begin n_fail++; $display("FAIL reset_disp: got %h expected 000", disp_out); end
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en: got %b expected 0", cnt_en); end
        n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_clr: got %b expected 0", cnt_clr); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
        // btn_start still high: accepted on the first edge after release.
        reset = 1'b0;
        @(negedge clk);
        btn_start = 1'b0;
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL reset_first_press: got %0d expected 1", state); end
        n_checks++; if (disp_out !== 12'h123) begin n_fail++; $display("FAIL reset_disp_live: got %h expected 123", disp_out); end
    endtask

    task automatic test_basic_count();
        int pulses;
        logic exp_en;
        do_reset();
        cnt_in = 12'h000;
        press_start();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL basic_state: got %0d expected 1", state); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL basic_running: got %b expected 1", running); end
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL basic_en_first: got %b expected 0", cnt_en); end
        pulses = 0;
        for (int k = 2; k <= 13; k++) begin
            @(negedge clk);
            exp_en = ((k % 4) == 0);
            n_checks++; if (cnt_en !== exp_en) begin n_fail++; $display("FAIL basic_en_cycle%0d: got %b expected %b", k, cnt_en, exp_en); end
            if (cnt_en === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL basic_pulse_count: got %0d expected 3", pulses); end
    endtask

    // Entered two cycles after the last tick of test_basic_count.
    task automatic test_stop_resume();
        press_start();
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL stop_state: got %0d expected 2", state); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL stop_running: got %b expected 0", running); end
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL stop_no_en%0d: got %b expected 0", k, cnt_en); end
            @(negedge clk);
        end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL stop_held: got %0d expected 2", state); end
        press_start();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL resume_state: got %0d expected 1", state); end
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL resume_en0: got %b expected 0", cnt_en); end
        @(negedge clk);
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL resume_en1: got %b expected 0", cnt_en); end
        @(negedge clk);
        n_checks++; if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL resume_en2: got %b expected 1", cnt_en); end
    endtask

    // Entered in RUN with the prescaler just wrapped.
    task automatic test_lap();
        logic [11:0] seq [4];
        int pulses;
        seq[0] = 12'h026; seq[1] = 12'h027; seq[2] = 12'h030; seq[3] = 12'h031;
        cnt_in = 12'h025;
        press_lap();
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL lap_state: got %0d expected 3", state); end
        n_checks++; if (lap_active !== 1'b1) begin n_fail++; $display("FAIL lap_active: got %b expected 1", lap_active); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL lap_running: got %b expected 1", running); end
        n_checks++; if (disp_out !== 12'h025) begin n_fail++; $display("FAIL lap_capture: got %h expected 025", disp_out); end
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            cnt_in = seq[k];
            @(negedge clk);
            n_checks++; if (disp_out !== 12'h025) begin n_fail++; $display("FAIL lap_hold%0d: got %h expected 025", k, disp_out); end
            if (cnt_en === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL lap_tick_count: got %0d expected 1", pulses); end
        press_lap();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL lap_release_state: got %0d expected 1", state); end
        n_checks++; if (lap_active !== 1'b0) begin n_fail++; $display("FAIL lap_release_active: got %b expected 0", lap_active); end
        n_checks++; if (disp_out !== 12'h031) begin n_fail++; $display("FAIL lap_release_disp: got %h expected 031", disp_out); end
        cnt_in = 12'h032;
        @(negedge clk);
        n_checks++; if (disp_out !== 12'h032) begin n_fail++; $display("FAIL lap_live_follow: got %h expected 032", disp_out); end
    endtask

    // Entered in RUN.
    task automatic test_clear();
        press_start();
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL clear_pre_stop: got %0d expected 2", state); end
        n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL clear_pre_clr: got %b expected 0", cnt_clr); end
        press_lap();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL clear_stop_state: got %0d expected 0", state); end
        n_checks++; if (cnt_clr !== 1'b1) begin n_fail++; $display("FAIL clear_stop_pulse: got %b expected 1", cnt_clr); end
        @(negedge clk);
        n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL clear_stop_end: got %b expected 0", cnt_clr); end
        press_lap();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL clear_idle_state: got %0d expected 0", state); end
        n_checks++; if (cnt_clr !== 1'b1) begin n_fail++; $display("FAIL clear_idle_pulse: got %b expected 1", cnt_clr); end
        @(negedge clk);
        n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL clear_idle_end: got %b expected 0", cnt_clr); end
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL clear_idle_en: got %b expected 0", cnt_en); end
        // Prescaler was zeroed in IDLE: a full four-cycle tick follows start.
        press_start();
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL clear_zero_en0: got %b expected 0", cnt_en); end
        @(negedge clk);
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL clear_zero_en1: got %b expected 0", cnt_en); end
        @(negedge clk);
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL clear_zero_en2: got %b expected 0", cnt_en); end
        @(negedge clk);
        n_checks++; if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL clear_zero_en3: got %b expected 1", cnt_en); end
    endtask

    // Entered in RUN.
    task automatic test_simultaneous();
        btn_start = 1'b1;
        btn_lap   = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL simul_state: got %0d expected 2", state); end
        n_checks++; if (lap_active !== 1'b0) begin n_fail++; $display("FAIL simul_lap_active: got %b expected 0", lap_active); end
        n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL simul_cnt_clr: got %b expected 0", cnt_clr); end
    endtask

    // Entered in STOP.
    task automatic test_reset_mid_lap();
        cnt_in = 12'h5a5;
        press_start();
        press_lap();
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL rlap_pre_state: got %0d expected 3", state); end
        n_checks++; if (disp_out !== 12'h5a5) begin n_fail++; $display("FAIL rlap_pre_disp: got %h expected 5a5", disp_out); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rlap_async_state: got %0d expected 0", state); end
        n_checks++; if (disp_out !== 12'h000) begin n_fail++; $display("FAIL rlap_async_disp: got %h expected 000", disp_out); end
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL rlap_async_en: got %b expected 0", cnt_en); end
        n_checks++; if (lap_active !== 1'b0) begin n_fail++; $display("FAIL rlap_async_lap: got %b expected 0", lap_active); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rlap_after_state: got %0d expected 0", state); end
        n_checks++; if (disp_out !== 12'h5a5) begin n_fail++; $display("FAIL rlap_after_disp: got %h expected 5a5", disp_out); end
    endtask

    initial begin
        reset     = 1'b1;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        cnt_in    = 12'h000;
        @(negedge clk);
        test_reset();
        test_basic_count();
        test_stop_resume();
        test_lap();
        test_clear();
        test_simultaneous();
        test_reset_mid_lap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning clocks per count-enable tick; legal range 2..65535.
REQ-002 SHALL have parameter DW, default 12, meaning width of the digit-chain value bus.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_start  input  1  one-cycle pulse toggling run/stop.
REQ-006 SHALL have port btn_lap  input  1  one-cycle pulse for lap freeze/release, or clear when stopped.
REQ-007 SHALL have port cnt_in  input  DW  current value of the external counter-digit chain.
REQ-008 SHALL have port cnt_en  output  1  carry-in to the least-significant digit; one-cycle pulse per tick.
REQ-009 SHALL have port cnt_clr  output  1  one-cycle clear pulse to the digit chain.
REQ-010 SHALL have port disp_out  output  DW  value to display, either live or lap-frozen.
REQ-011 SHALL have port running  output  1  high in RUN or LAP.
REQ-012 SHALL have port lap_active  output  1  high in LAP.
REQ-013 SHALL have port state  output  2  encoded FSM state: IDLE=0, RUN=1, STOP=2, LAP=3.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, STOP and LAP, all registered.
REQ-015 SHALL take these IDLE transitions: btn_start -> RUN; btn_lap -> stay in IDLE and pulse cnt_clr.
REQ-016 SHALL take these RUN transitions: btn_start -> STOP; btn_lap -> LAP, capturing cnt_in into disp_out.
REQ-017 SHALL take these LAP transitions: btn_start -> STOP with disp_out returning to live; btn_lap -> RUN with disp_out returning to live.
REQ-018 SHALL take these STOP transitions: btn_start -> RUN; btn_lap -> IDLE with a cnt_clr pulse.
REQ-019 SHALL give btn_start priority when btn_start and btn_lap are high in the same cycle; btn_lap is then ignored.
REQ-020 SHALL drive cnt_clr high for exactly the one cycle after the accepted btn_lap edge, and never otherwise.
REQ-021 SHALL keep a prescaler counting 0..TICK_DIV-1 only in RUN/LAP, wrapping to 0 after TICK_DIV-1.
REQ-022 SHALL assert cnt_en (registered) for exactly one cycle each time the prescaler wraps; cnt_en is never high in IDLE or STOP.
REQ-023 SHALL hold the prescaler value in STOP, so resuming continues the partial tick.
REQ-024 SHALL zero the prescaler on entry to IDLE.
REQ-025 SHALL register disp_out from cnt_in every cycle outside LAP (1-cycle latency).
REQ-026 SHALL hold disp_out in LAP at the cnt_in value sampled on the cycle btn_lap was accepted.
REQ-027 SHALL keep running and lap_active as pure decodes of the registered state.

Reset
REQ-028 SHALL, while reset is high, asynchronously force state=IDLE, prescaler=0, cnt_en=0, cnt_clr=0, disp_out=0.
REQ-029 SHALL, on reset asserted mid-RUN or mid-LAP, drop cnt_en immediately and discard the frozen lap value.
REQ-030 SHALL ignore button pulses arriving during reset; the first button press is accepted on the first edge after deassertion.

Structure
REQ-031 SHALL define in shared package stopwatch_pkg: the state enum (IDLE/RUN/STOP/LAP, 2-bit) and the default TICK_DIV constant.
REQ-032 SHALL place the prescaler in sub-module tick_gen (ports clk, reset, run, zero, tick); the FSM and display hold stay in stopwatch_ctrl.

Verification (TICK_DIV=4, DW=12)
REQ-033 SHALL verify basic counting: reset, then btn_start -> state=1; cnt_en pulses every 4th cycle; 3 pulses in 12 cycles.
REQ-034 SHALL verify stop/resume: btn_start 2 cycles after a tick -> state=2, no cnt_en for 10 cycles; btn_start -> the next cnt_en arrives 2 cycles later.
REQ-035 SHALL verify lap: in RUN with cnt_in=12'h025, btn_lap -> disp_out=12'h025 held while cnt_in advances to 12'h031; btn_lap -> disp_out follows cnt_in 1 cycle later.
REQ-036 SHALL verify clear: in STOP, btn_lap -> state=0 and cnt_clr high for exactly 1 cycle; in IDLE, btn_lap -> cnt_clr pulses and state stays 0.
REQ-037 SHALL verify simultaneous buttons: in RUN, btn_start=btn_lap=1 in one cycle -> state=2, lap_active=0, no cnt_clr.
REQ-038 SHALL verify reset mid-LAP: assert reset asynchronously -> state=0, disp_out=0, cnt_en=0 before the next clock edge.
